// File: rtl/muldiv_pkg.sv
// Shared encodings for the unsigned multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer: shift-add multiply or restoring divide.
module muldiv_step import muldiv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   b,
  input  logic              op,
  output logic [2*XLEN-1:0] nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;

  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b} : '0);
    // Upper half of acc<<1; the partial remainder never reaches bit 2*XLEN-1.
    diff = {1'b0, acc[2*XLEN-2:XLEN-1]} - {1'b0, b};
    nxt  = {sum, acc[XLEN-1:1]};
    if (op == OP_DIVU) begin
      if (!diff[XLEN])
        nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        nxt = {acc[2*XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer producing the {Hi, Lo} write for HiLo.
module muldiv_seq import muldiv_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  output logic              busy,
  output logic              done,
  output logic              hilo_we,
  output logic [2*XLEN-1:0] hilo_data,
  output logic              div_zero
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN-1:0]   b_reg;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc (acc),
    .b   (b_reg),
    .op  (state == S_DIV),
    .nxt (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hilo_we   <= 1'b0;
      hilo_data <= '0;
      div_zero  <= 1'b0;
    end else begin
      done    <= 1'b0;
      hilo_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt      <= '0;
            busy     <= 1'b1;
            div_zero <= 1'b0;
            b_reg    <= src_b;
            if (op == OP_MULTU) begin
              acc   <= {{XLEN{1'b0}}, src_b};
              b_reg <= src_a;
              state <= S_MUL;
            end else if (src_b != '0) begin
              acc   <= {{XLEN{1'b0}}, src_a};
              state <= S_DIV;
            end else begin
              // Divide by zero skips iteration: Hi = dividend, Lo = all-ones.
              acc       <= {src_a, {XLEN{1'b1}}};
              hilo_data <= {src_a, {XLEN{1'b1}}};
              div_zero  <= 1'b1;
              done      <= 1'b1;
              hilo_we   <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            // Strobes are registered so they are high during the DONE cycle.
            hilo_data <= acc_nxt;
            done      <= 1'b1;
            hilo_we   <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_seq;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [31:0] src_a, src_b;
  logic        busy, done, hilo_we, div_zero;
  logic [63:0] hilo_data;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;

  muldiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .busy      (busy),
    .done      (done),
    .hilo_we   (hilo_we),
    .hilo_data (hilo_data),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (hilo_we) we_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic o, input logic [31:0] a, input logic [31:0] b);
    if (!o) return 64'(a) * 64'(b);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Issue one op; optionally pulse a conflicting start at in-flight cycle ign_at.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input int ign_at, input string tag);
    logic [63:0] exp;
    int lat, exp_lat, busy_bad, we0;
    exp     = ref_result(o, a, b);
    exp_lat = (o && b == 32'd0) ? 1 : XLEN + 1;
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = $urandom; src_a = $urandom; src_b = $urandom;
    we0 = we_cnt;
    lat = 0; busy_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!busy) busy_bad++;
      if (ign_at != 0 && lat == ign_at) begin
        start = 1'b1; op = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_0003;
      end else begin
        start = 1'b0;
      end
    end while (!hilo_we && lat < 40);
    start = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_data"}, hilo_data, exp);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_inflight"}, busy_bad, 0);
    chk({tag, "_div_zero"}, div_zero, (o && b == 32'd0));
    @(negedge clk);
    chk({tag, "_we_pulse"}, hilo_we, 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_data_hold"}, hilo_data, exp);
    chk({tag, "_we_count"}, we_cnt - we0, 1);
  endtask

  initial begin
    int we0;
    logic        ro;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", hilo_we, 0);
    chk("rst_data", hilo_data, 0);
    chk("rst_div_zero", div_zero, 0);
    reset = 1'b0;

    run_op(1'b0, 32'h0000_0007, 32'h0000_0006, 0, "mul_7x6");
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_max");
    run_op(1'b1, 32'd100, 32'd7, 0, "div_100_7");
    run_op(1'b1, 32'h1234_5678, 32'd0, 0, "div_by_zero");
    repeat (3) @(negedge clk);
    chk("div_zero_held", div_zero, 1);

    we0 = we_cnt;
    run_op(1'b0, 32'h0001_2345, 32'h0000_6789, 10, "mul_ignored_start");
    repeat (40) @(negedge clk);
    chk("ignored_start_single_we", we_cnt - we0, 1);
    chk("ignored_start_idle", busy, 0);

    // Abort a DIVU partway through with reset.
    @(negedge clk);
    start = 1'b1; op = 1'b1; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    we0 = we_cnt;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_data", hilo_data, 0);
    chk("abort_we", hilo_we, 0);
    repeat (40) @(negedge clk);
    chk("abort_no_we", we_cnt - we0, 0);
    run_op(1'b0, 32'd3, 32'd5, 0, "mul_after_abort");

    for (int i = 0; i < 16; i++) begin
      ro = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = rb & 32'h0000_00FF;
      if (i % 5 == 0) begin rb = 32'd0; ro = 1'b1; end
      run_op(ro, ra, rb, 0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
